// File: rtl/cla_seq_adder_if.sv
// Request/result bundle between a requester and the digit-serial CLA adder.
interface cla_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/cla_seq_adder.sv
// Digit-serial wide adder: one 4-bit carry-lookahead slice reused per clock,
// carry chained between digits through a register.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p_s;
  logic [3:0] g_s;
  logic [4:0] c_s;

  assign p_s    = a ^ b;
  assign g_s    = a & b;
  assign c_s[0] = cin;
  assign c_s[1] = g_s[0] | (p_s[0] & c_s[0]);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);
  assign sum    = p_s ^ c_s[3:0];
  assign cout   = c_s[4];
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cla_seq_adder_if.slave   bus
);
  localparam int NDIG = WIDTH / 4;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_s;
  logic [IDXW-1:0]  idx_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic [3:0]       dig_a_s;
  logic [3:0]       dig_b_s;
  logic [3:0]       dig_sum_s;
  logic             dig_cout_s;
  logic             last_s;

  assign dig_a_s = a_r[{idx_r, 2'b00} +: 4];
  assign dig_b_s = b_r[{idx_r, 2'b00} +: 4];
  assign last_s  = (idx_r == IDXW'(NDIG - 1));

  cla_4bit u_slice (
    .a    (dig_a_s),
    .b    (dig_b_s),
    .cin  (carry_r),
    .sum  (dig_sum_s),
    .cout (dig_cout_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) next_s = RUN;
        else           next_s = IDLE;
      end
      RUN: begin
        if (last_s) next_s = DONE;
        else        next_s = RUN;
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Operand latch, digit walk and result capture; results hold outside RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r   <= {IDXW{1'b0}};
      carry_r <= 1'b0;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            carry_r <= bus.cin;
            idx_r   <= {IDXW{1'b0}};
          end
        end
        RUN: begin
          sum_r[{idx_r, 2'b00} +: 4] <= dig_sum_s;
          carry_r                    <= dig_cout_s;
          idx_r                      <= idx_r + IDXW'(1);
          if (last_s) cout_r <= dig_cout_s;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_r == RUN);
  assign bus.done = (state_r == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed and randomised checks of cla_seq_adder at WIDTH=16 and WIDTH=4.
module tb_cla_seq_adder;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cla_seq_adder_if #(.WIDTH(16)) if16 ();
  cla_seq_adder_if #(.WIDTH(4))  if4  ();

  cla_seq_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  cla_seq_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one 16-bit operation and reports busy cycles, done position and result.
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                      output int busy_n, output int done_at,
                      output logic [15:0] s, output logic c);
    if16.a = ta; if16.b = tb; if16.cin = tc; if16.start = 1'b1;
    tick;
    if16.start = 1'b0;
    busy_n = 0; done_at = 0;
    for (int k = 1; k <= 12 && done_at == 0; k++) begin
      if (if16.busy === 1'b1) busy_n++;
      if (if16.done === 1'b1) done_at = k;
      else tick;
    end
    s = if16.sum; c = if16.cout;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    if16.start = 1'b0; if16.a = 16'h0; if16.b = 16'h0; if16.cin = 1'b0;
    if4.start = 1'b0;  if4.a = 4'h0;   if4.b = 4'h0;   if4.cin = 1'b0;
    tick; tick;
    n_checks++;
    if ({if16.busy, if16.done, if16.cout, if16.sum} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset16: got busy=%b done=%b cout=%b sum=%h, want all 0",
               if16.busy, if16.done, if16.cout, if16.sum);
    end
    n_checks++;
    if ({if4.busy, if4.done, if4.cout, if4.sum} !== 7'h0) begin
      n_fail++;
      $display("FAIL reset4: got busy=%b done=%b cout=%b sum=%h, want all 0",
               if4.busy, if4.done, if4.cout, if4.sum);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_vectors;
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic        vc [6];
    logic [15:0] es [6];
    logic        ec [6];
    int bn, da;
    logic [15:0] s;
    logic c;
    va = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h1234, 16'hAAAA, 16'h8000};
    vb = '{16'h0000, 16'h0001, 16'h0000, 16'h4321, 16'h5555, 16'h8000};
    vc = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0};
    es = '{16'h0000, 16'h0000, 16'h0000, 16'h5556, 16'h0000, 16'h0000};
    ec = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b1,     1'b1};
    for (int i = 0; i < 6; i++) begin
      op16(va[i], vb[i], vc[i], bn, da, s, c);
      n_checks++;
      if (bn !== 4 || da !== 5) begin
        n_fail++;
        $display("FAIL timing16 vec%0d: got busy=%0d done_at=%0d, want 4 and 5", i, bn, da);
      end
      n_checks++;
      if ({c, s} !== {ec[i], es[i]}) begin
        n_fail++;
        $display("FAIL result16 vec%0d: got cout=%b sum=%h, want cout=%b sum=%h",
                 i, c, s, ec[i], es[i]);
      end
    end
  endtask

  task automatic test_isolation;
    int dones;
    dones = 0;
    if16.a = 16'h0F0F; if16.b = 16'h00F1; if16.cin = 1'b0; if16.start = 1'b1;
    tick;
    if16.start = 1'b0;
    tick;
    if16.start = 1'b1; if16.a = 16'hFFFF; if16.b = 16'hFFFF; if16.cin = 1'b1;
    tick;
    if16.a = 16'h1234; if16.b = 16'h5678;
    tick;
    if16.start = 1'b0;
    tick;
    n_checks++;
    if (if16.done !== 1'b1 || if16.sum !== 16'h1000 || if16.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL isolation_result: got done=%b sum=%h cout=%b, want 1 1000 0",
               if16.done, if16.sum, if16.cout);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      if (if16.done === 1'b1 || if16.busy === 1'b1) dones++;
      n_checks++;
      if (if16.sum !== 16'h1000 || if16.cout !== 1'b0) begin
        n_fail++;
        $display("FAIL isolation_hold%0d: got sum=%h cout=%b, want 1000 0",
                 k, if16.sum, if16.cout);
      end
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL isolation_no_restart: got %0d busy/done cycles, want 0", dones);
    end
  endtask

  task automatic test_reset_mid;
    int bn, da;
    logic [15:0] s;
    logic c;
    if16.a = 16'h1111; if16.b = 16'h2222; if16.cin = 1'b0; if16.start = 1'b1;
    tick;
    if16.start = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    n_checks++;
    if ({if16.busy, if16.done, if16.cout, if16.sum} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b cout=%b sum=%h, want all 0",
               if16.busy, if16.done, if16.cout, if16.sum);
    end
    tick;
    n_checks++;
    if (if16.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got busy=%b, want 0", if16.busy);
    end
    op16(16'h0001, 16'h0001, 1'b0, bn, da, s, c);
    n_checks++;
    if ({c, s} !== 17'h00002 || da !== 5) begin
      n_fail++;
      $display("FAIL reset_mid_after: got cout=%b sum=%h done_at=%0d, want 0 0002 5", c, s, da);
    end
  endtask

  task automatic test_width4;
    int bn, da;
    if4.a = 4'hF; if4.b = 4'h1; if4.cin = 1'b1; if4.start = 1'b1;
    tick;
    if4.start = 1'b0;
    bn = 0; da = 0;
    for (int k = 1; k <= 6 && da == 0; k++) begin
      if (if4.busy === 1'b1) bn++;
      if (if4.done === 1'b1) da = k;
      else tick;
    end
    n_checks++;
    if (bn !== 1 || da !== 2) begin
      n_fail++;
      $display("FAIL timing4: got busy=%0d done_at=%0d, want 1 and 2", bn, da);
    end
    n_checks++;
    if (if4.sum !== 4'h1 || if4.cout !== 1'b1) begin
      n_fail++;
      $display("FAIL result4: got sum=%h cout=%b, want 1 1", if4.sum, if4.cout);
    end
    tick;
    n_checks++;
    if (if4.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done4_pulse: got done=%b, want 0", if4.done);
    end
  endtask

  task automatic test_random;
    logic [15:0] ra, rb, s;
    logic        rc, c;
    logic [16:0] exp;
    int bn, da;
    for (int i = 0; i < 200; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      op16(ra, rb, rc, bn, da, s, c);
      n_checks++;
      if ({c, s} !== exp || da !== 5) begin
        n_fail++;
        $display("FAIL random%0d: %h+%h+%b got %h (done_at=%0d), want %h at 5",
                 i, ra, rb, rc, {c, s}, da, exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_vectors;
    test_isolation;
    test_reset_mid;
    test_width4;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle wide adder built around one cla_4bit slice.
- Latches two WIDTH-bit operands, then feeds them to the 4-bit CLA one digit per clock, least significant digit first.
- Each digit's sum nibble is captured and its carry-out is registered as the next digit's carry-in.
- Sits directly upstream of cla_4bit, driving its a/b/cin and consuming its sum/cout.
- Gives the datapath area-cheap wide addition with a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of 4 and at least 4. Digit count NDIG = WIDTH/4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled when start is accepted.
- b  input  WIDTH  operand B; sampled when start is accepted.
- cin  input  1  carry-in; sampled when start is accepted.
- busy  output  1  high while digits are being processed (RUN).
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result.
- cout  output  1  registered final carry-out.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset state:
  - state=IDLE, digit index=0, internal carry=0.
  - Operand registers cleared.
  - busy=0, done=0, sum=0, cout=0.
- IDLE:
  - On an edge with start=1: latch a, b; carry<=cin; idx<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - On each edge, drive the cla_4bit slice with a_lat[4*idx+:4], b_lat[4*idx+:4] and carry.
  - Write the slice sum into sum[4*idx+:4]; carry<=slice cout; idx<=idx+1.
  - When idx==NDIG-1, also set cout<=slice cout and go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge: return to IDLE unconditionally.
- Outputs:
  - busy = (state==RUN); done = (state==DONE). Both come from the registered state.
- Latency:
  - start accepted at edge 0; digits processed at edges 1..NDIG.
  - done is high in the cycle after edge NDIG.
  - Accept-to-done is NDIG+1 cycles; start-to-start minimum spacing is NDIG+2 cycles.
- start outside IDLE:
  - start high in RUN or DONE is ignored.
  - It is not queued; the requester must reassert it in IDLE.
- Operand isolation: a, b, cin changing while not in IDLE have no effect, because operands are latched.
- Result hold:
  - sum and cout hold their final values from DONE through IDLE.
  - They change only when the next operation's RUN edges overwrite them.
  - sum shows partial digits during RUN; consumers qualify with done.
  - cout updates only on the last-digit edge.
- Arithmetic:
  - {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
  - The carry propagates across digits only through the carry register; there is no combinational wide path.
- Reset mid-operation: rst_n=0 on any edge forces the full reset state immediately; the partial result is discarded.
- Degenerate case WIDTH=4:
  - A single RUN cycle, then DONE.
  - busy is high for exactly 1 cycle.

Test Plan:
- WIDTH=16, a=0x0000, b=0x0000, cin=0, start pulse -> busy high 4 cycles; done pulse on the 5th cycle after accept; sum=0x0000, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all 4 digits; sum=0x0000, cout=1. a=0xFFFF, b=0x0000, cin=1 -> same result.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. a=0xAAAA, b=0x5555, cin=1 -> sum=0x0000, cout=1.
- Start and operand isolation:
  - Start with a=0x0F0F, b=0x00F1, cin=0.
  - Two cycles later assert start with a=0xFFFF, b=0xFFFF, and change a/b.
  - Expected: sum=0x1000, cout=0; second start ignored; no second done.
  - Result then holds for 3 idle cycles.
- Reset mid-operation: rst_n low for 1 edge during RUN idx=2 -> busy=0, done=0, sum=0, cout=0 next cycle. A following start a=0x0001, b=0x0001 -> sum=0x0002.
- WIDTH=4 instance: a=0xF, b=0x1, cin=1 -> busy 1 cycle, then done; sum=0x1, cout=1. Randomised 200-pair compare against the golden a+b+cin for WIDTH=16.
